pipeline_hazard_ctrl: RTL and testbench

//   Sequences the pipeline's instruction frames (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline frame enables, bubbles and flushes for load-use, branch and memory-wait hazards
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT   = 64,
    parameter int CNT_W         = 16,
    parameter int REGADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REGADDR_WIDTH-1:0] id_aLoc,
    input  logic [REGADDR_WIDTH-1:0] id_bLoc,
    input  logic                     id_aUsed,
    input  logic                     id_bUsed,
    input  logic                     ex_load,
    input  logic                     ex_writeEnable,
    input  logic [REGADDR_WIDTH-1:0] ex_writeSelect,
    input  logic                     ex_pcOverwrite,
    input  logic                     mem_load,
    input  logic                     mem_store,
    input  logic                     mem_ready,
    output logic                     fetch_we,
    output logic                     if_id_flush,
    output logic                     id_ex_we,
    output logic                     id_ex_bubble,
    output logic                     ex_mem_we,
    output logic                     mem_wb_we,
    output logic                     pc_redirect,
    output logic                     mem_error,
    output logic [CNT_W-1:0]         stall_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic lu, busy;
    logic fetch_we_c, if_id_flush_c, id_ex_we_c, id_ex_bubble_c;
    logic ex_mem_we_c, mem_wb_we_c, pc_redirect_c;

    always_comb begin
        lu = ex_load && ex_writeEnable && (ex_writeSelect != '0) &&
             ((id_aUsed && (id_aLoc == ex_writeSelect)) ||
              (id_bUsed && (id_bLoc == ex_writeSelect)));
        busy = (mem_load || mem_store) && !mem_ready;
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_error_d    = mem_error_q;
        fetch_we_c     = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_we_c     = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_mem_we_c    = 1'b0;
        mem_wb_we_c    = 1'b0;
        pc_redirect_c  = 1'b0;

        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (busy) begin
                    if (state_q == ST_RUN) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WC_ONE;
                    end else if (wait_cnt_q == WC_LAST) begin
                        state_d     = ST_ERROR;
                        mem_error_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_ONE;
                    end
                end else begin
                    // Release from MEM_WAIT applies the hazard decision in the same cycle.
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    if (ex_pcOverwrite) begin
                        fetch_we_c     = 1'b1;
                        id_ex_we_c     = 1'b1;
                        ex_mem_we_c    = 1'b1;
                        mem_wb_we_c    = 1'b1;
                        pc_redirect_c  = 1'b1;
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                    end else if (lu) begin
                        id_ex_we_c     = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        ex_mem_we_c    = 1'b1;
                        mem_wb_we_c    = 1'b1;
                    end else begin
                        fetch_we_c  = 1'b1;
                        id_ex_we_c  = 1'b1;
                        ex_mem_we_c = 1'b1;
                        mem_wb_we_c = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                mem_error_d = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!fetch_we_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        fetch_we     = fetch_we_c     && !reset;
        if_id_flush  = if_id_flush_c  && !reset;
        id_ex_we     = id_ex_we_c     && !reset;
        id_ex_bubble = id_ex_bubble_c && !reset;
        ex_mem_we    = ex_mem_we_c    && !reset;
        mem_wb_we    = mem_wb_we_c    && !reset;
        pc_redirect  = pc_redirect_c  && !reset;
        mem_error    = mem_error_q    && !reset;
        stall_count  = reset ? '0 : stall_cnt_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_NORM = 7'b1010110;
    localparam logic [6:0] O_LU   = 7'b0011110;
    localparam logic [6:0] O_BR   = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_aLoc, id_bLoc, ex_writeSelect;
    logic id_aUsed, id_bUsed, ex_load, ex_writeEnable, ex_pcOverwrite;
    logic mem_load, mem_store, mem_ready;
    logic fetch_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we, pc_redirect;
    logic mem_error;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W), .REGADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .id_aLoc(id_aLoc), .id_bLoc(id_bLoc), .id_aUsed(id_aUsed), .id_bUsed(id_bUsed),
        .ex_load(ex_load), .ex_writeEnable(ex_writeEnable), .ex_writeSelect(ex_writeSelect),
        .ex_pcOverwrite(ex_pcOverwrite),
        .mem_load(mem_load), .mem_store(mem_store), .mem_ready(mem_ready),
        .fetch_we(fetch_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
        .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .pc_redirect(pc_redirect), .mem_error(mem_error), .stall_count(stall_count)
    );

    typedef struct {
        string      name;
        logic [4:0] a_loc, b_loc, ws;
        logic       a_used, b_used, ld, we, pc_ow;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [6:0] outs();
        return {fetch_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we, pc_redirect};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_in();
        id_aLoc = 0; id_bLoc = 0; ex_writeSelect = 0;
        id_aUsed = 0; id_bUsed = 0; ex_load = 0; ex_writeEnable = 0; ex_pcOverwrite = 0;
        mem_load = 0; mem_store = 0; mem_ready = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        id_aLoc = v.a_loc; id_bLoc = v.b_loc; ex_writeSelect = v.ws;
        id_aUsed = v.a_used; id_bUsed = v.b_used; ex_load = v.ld;
        ex_writeEnable = v.we; ex_pcOverwrite = v.pc_ow;
    endtask

    task automatic stall_step(input logic [6:0] exp_out);
        if (exp_out[6] == 1'b0 && exp_stall < 15) exp_stall++;
    endtask

    task automatic cyc_check(input string name, input logic [6:0] exp_out);
        @(negedge clk);
        check({name, "_outs"}, 32'(outs()), 32'(exp_out));
        stall_step(exp_out);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, O_NORM};
        vecs[1]  = '{"lu_rs2",      0, 5, 5, 0, 1, 1, 1, 0, O_LU};
        vecs[2]  = '{"after_lu",    0, 5, 5, 0, 1, 0, 0, 0, O_NORM};
        vecs[3]  = '{"ws_zero",     0, 0, 0, 1, 0, 1, 1, 0, O_NORM};
        vecs[4]  = '{"lu_rs1",      7, 0, 7, 1, 0, 1, 1, 0, O_LU};
        vecs[5]  = '{"rs1_unused",  7, 0, 7, 0, 0, 1, 1, 0, O_NORM};
        vecs[6]  = '{"no_wr",       7, 7, 7, 1, 1, 1, 0, 0, O_NORM};
        vecs[7]  = '{"alu_dep",     7, 7, 7, 1, 1, 0, 1, 0, O_NORM};
        vecs[8]  = '{"br_beats_lu", 0, 5, 5, 0, 1, 1, 1, 1, O_BR};
        vecs[9]  = '{"branch",      0, 0, 0, 0, 0, 0, 0, 1, O_BR};
        vecs[10] = '{"no_match",    3, 4, 9, 1, 1, 1, 1, 0, O_NORM};

        clear_in();
        reset = 1'b1;
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'(O_NONE));
        check("reset_stall", 32'(stall_count), 0);
        check("reset_err", 32'(mem_error), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply_vec(vecs[i]);
            cyc_check(vecs[i].name, vecs[i].exp);
            check({vecs[i].name, "_stall"}, 32'(stall_count), 32'(exp_stall));
            check({vecs[i].name, "_err"}, 32'(mem_error), 0);
        end
        clear_in();

        // memory load waits three cycles, releases on the fourth
        mem_load = 1;
        for (int i = 0; i < 3; i++) cyc_check("ld_wait", O_NONE);
        mem_ready = 1;
        cyc_check("ld_release", O_NORM);
        check("ld_stall", 32'(stall_count), 32'(exp_stall));
        clear_in();

        // store request dropped while waiting counts as ready
        mem_store = 1;
        cyc_check("st_wait", O_NONE);
        mem_store = 0;
        cyc_check("st_drop", O_NORM);

        // release coinciding with a load-use hazard
        mem_load = 1;
        cyc_check("lu_wait", O_NONE);
        mem_ready = 1; ex_load = 1; ex_writeEnable = 1; ex_writeSelect = 5;
        id_bLoc = 5; id_bUsed = 1;
        cyc_check("lu_release", O_LU);
        check("lu_rel_stall", 32'(stall_count), 32'(exp_stall));
        clear_in();

        // reset in the middle of a wait
        mem_load = 1;
        cyc_check("rst_wait0", O_NONE);
        cyc_check("rst_wait1", O_NONE);
        reset = 1;
        @(negedge clk);
        check("rst_mid_outs", 32'(outs()), 32'(O_NONE));
        @(posedge clk); #1;
        reset = 0; mem_load = 0;
        exp_stall = 0;
        check("rst_mid_stall", 32'(stall_count), 0);
        cyc_check("rst_after", O_NORM);

        // timeout into sticky error, stall counter saturates
        mem_store = 1;
        for (int i = 0; i < 4; i++) begin
            check("to_err_pre", 32'(mem_error), 0);
            cyc_check("to_wait", O_NONE);
        end
        check("to_err_set", 32'(mem_error), 1);
        mem_store = 0; mem_ready = 1;
        for (int i = 0; i < 16; i++) begin
            cyc_check("err_hold", O_NONE);
            check("err_sticky", 32'(mem_error), 1);
            check("err_stall", 32'(stall_count), 32'(exp_stall));
        end
        check("stall_sat", 32'(stall_count), 15);

        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        exp_stall = 0;
        check("err_clr", 32'(mem_error), 0);
        cyc_check("post_err", O_NORM);
        check("post_err_stall", 32'(stall_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
